// File: rtl/xform_pkg.sv
// Shared types and constants for the character-transform datapath.
package xform_pkg;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int LINE_W = 8;
    localparam int PTR_W  = LEN_W + ADDR_W;

    // Character-memory address after reset; the first increment lands on 0.
    localparam logic [ADDR_W-1:0] MEM_ADDR_RST = 10'h3FF;

    typedef enum logic [2:0] {
        S_IDLE, S_PTR_A, S_PTR_D, S_RD_A, S_RD_D, S_SEND, S_NEXT, S_DONE
    } state_t;

    // Pointer entry layout: {len, start}
    function automatic logic [ADDR_W-1:0] ptr_start(input logic [PTR_W-1:0] p);
        return p[9:0];
    endfunction

    function automatic logic [LEN_W-1:0] ptr_len(input logic [PTR_W-1:0] p);
        return p[19:10];
    endfunction
endpackage

// File: rtl/line_scheduler_if.sv
// Output stream of character pairs with valid/ready handshake.
interface line_scheduler_if;
    import xform_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic              out_last;
    logic [LINE_W-1:0] out_line;

    modport master (output out_valid, out_data, out_last, out_line, input out_ready);
    modport slave  (input out_valid, out_data, out_last, out_line, output out_ready);
endinterface

// File: rtl/line_scheduler.sv
// Walks a range of lines, reads each line's pointer entry, and streams that
// line's character pairs one at a time. Both memories are 2-edge sync reads,
// so every read is an address cycle (_A) followed by a data cycle (_D).
module line_scheduler
    import xform_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [LINE_W-1:0]   first_line,
    input  logic [LINE_W-1:0]   num_lines,
    output logic [LINE_W-1:0]   ptr_line,
    input  logic [PTR_W-1:0]    ptr_data,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [15:0]         mem_dout,
    line_scheduler_if.master    out_if,
    output logic                busy,
    output logic                done
);

    state_t              state;
    logic [LINE_W-1:0]   lines_left;
    logic [LEN_W-1:0]    remaining;

    // Sequencer FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            lines_left       <= '0;
            remaining        <= '0;
            ptr_line         <= '0;
            mem_addr         <= MEM_ADDR_RST;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_last  <= 1'b0;
            out_if.out_line  <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        busy <= 1'b1;
                        if (num_lines != '0) begin
                            lines_left <= num_lines;
                            ptr_line   <= first_line;
                            state      <= S_PTR_A;
                        end else begin
                            // Empty request: finish immediately.
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_PTR_A: state <= S_PTR_D;
                S_PTR_D: begin
                    if (ptr_len(ptr_data) == '0) begin
                        state <= S_NEXT;          // zero-length line: skip silently
                    end else begin
                        mem_addr  <= ptr_start(ptr_data);
                        remaining <= ptr_len(ptr_data);
                        state     <= S_RD_A;
                    end
                end
                S_RD_A: state <= S_RD_D;
                S_RD_D: begin
                    out_if.out_data  <= mem_dout;
                    out_if.out_valid <= 1'b1;
                    out_if.out_last  <= (remaining == LEN_W'(1));
                    out_if.out_line  <= ptr_line;
                    state            <= S_SEND;
                end
                S_SEND: begin
                    // Outputs hold until the consumer takes the pair.
                    if (out_if.out_valid && out_if.out_ready) begin
                        out_if.out_valid <= 1'b0;
                        remaining        <= remaining - LEN_W'(1);
                        if (out_if.out_last) begin
                            state <= S_NEXT;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);   // wraps across 0x3FF
                            state    <= S_RD_A;
                        end
                    end
                end
                S_NEXT: begin
                    lines_left <= lines_left - LINE_W'(1);
                    if (lines_left == LINE_W'(1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        ptr_line <= ptr_line + LINE_W'(1);     // wraps 0xFF -> 0x00
                        state    <= S_PTR_A;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_scheduler.sv
// Directed bench for line_scheduler: memory models, a transaction-level
// expected-pair queue, and a per-cycle compare process on the output stream.
module tb_line_scheduler;
    import xform_pkg::*;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [7:0]  line;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [7:0]  first_line = '0;
    logic [7:0]  num_lines = '0;
    logic [7:0]  ptr_line;
    logic [19:0] ptr_data = '0;
    logic [9:0]  mem_addr;
    logic [15:0] mem_dout = '0;
    logic        busy, done;

    logic [19:0] ptr_tab [256];
    logic [15:0] cmem    [1024];

    pair_t exp_q [$];
    int n_chk = 0, n_fail = 0;
    int done_seen = 0;

    line_scheduler_if bus();

    line_scheduler dut (
        .clk(clk), .rst(rst), .go(go), .first_line(first_line), .num_lines(num_lines),
        .ptr_line(ptr_line), .ptr_data(ptr_data), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .out_if(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: address at edge k, sampled by DUT at k+2.
    always @(posedge clk) begin
        ptr_data <= ptr_tab[ptr_line];
        mem_dout <= cmem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream straight from the rules: every pair of every non-empty line.
    task automatic build(input logic [7:0] f, input logic [7:0] n);
        pair_t p;
        exp_q.delete();
        for (int l = 0; l < int'(n); l++) begin
            logic [7:0]  ln;
            logic [19:0] e;
            ln = f + 8'(l);
            e  = ptr_tab[ln];
            for (int i = 0; i < int'(e[19:10]); i++) begin
                p.data = cmem[10'((int'(e[9:0]) + i) % 1024)];
                p.last = (i == int'(e[19:10]) - 1);
                p.line = ln;
                exp_q.push_back(p);
            end
        end
    endtask

    // Compare process: handshakes against the queue, hold stability under backpressure.
    logic        stall_prev = 1'b0;
    logic [15:0] hold_data;
    logic [9:0]  hold_addr;
    always @(negedge clk) begin
        pair_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (done) done_seen++;
            if (bus.out_valid) begin
                if (stall_prev) begin
                    chk("hold_data", 32'(bus.out_data), 32'(hold_data));
                    chk("hold_addr", 32'(mem_addr), 32'(hold_addr));
                end
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pair_qsize", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pair_data", 32'(bus.out_data), 32'(e.data));
                        chk("pair_last", 32'(bus.out_last), 32'(e.last));
                        chk("pair_line", 32'(bus.out_line), 32'(e.line));
                    end
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    hold_data  = bus.out_data;
                    hold_addr  = mem_addr;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // One request; cycles counted from the edge that samples go (cyc 0 = just after it).
    task automatic run(input logic [7:0] f, input logic [7:0] n, input int stall_pair,
                       input int exp_first, input int exp_done);
        int d0, pair, stall_left, cyc, first_v, done_c;
        logic pv, busy0;
        d0 = done_seen;
        @(posedge clk); #1;
        go = 1'b1; first_line = f; num_lines = n; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; first_line = f + 8'd9; num_lines = 8'd4;   // must not matter after go
        cyc = 0; pair = -1; stall_left = 0; first_v = -1; done_c = -1; pv = 1'b0;
        busy0 = busy;
        while (cyc < 600 && done_c < 0) begin
            if (done) done_c = cyc;
            if (bus.out_valid && !pv) begin
                pair++;
                if (first_v < 0) first_v = cyc;
                if (pair == stall_pair) stall_left = 5;
            end
            pv = bus.out_valid;
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            // A go while busy must be ignored.
            go = (n != 0 && cyc == 2);
            if (done_c < 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        go = 1'b0;
        chk("busy_after_go", 32'(busy0), 32'd1);
        chk("done_cycle", 32'(done_c), 32'(exp_done));
        chk("first_valid_cycle", 32'(first_v), 32'(exp_first));
        @(posedge clk); #1;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("done_count", 32'(done_seen - d0), 32'd1);
        chk("pairs_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0, w;
        for (int i = 0; i < 256; i++) ptr_tab[i] = '0;
        for (int i = 0; i < 1024; i++) cmem[i] = 16'hC000 | 16'(i);
        bus.out_ready = 1'b1;

        // Reset with go held: nothing may start.
        rst = 1'b1; go = 1'b1; first_line = 8'd3; num_lines = 8'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr", 32'(mem_addr), 32'h3FF);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ptr_line", 32'(ptr_line), 32'd0);
        rst = 1'b0; go = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_rst", 32'(busy), 32'd0);

        // One line, ready high.
        ptr_tab[5] = {10'd3, 10'h010};
        cmem[10'h010] = 16'h4161; cmem[10'h011] = 16'h4262; cmem[10'h012] = 16'h4363;
        build(8'd5, 8'd1);
        chk("model_size", 32'(exp_q.size()), 32'd3);
        chk("model_tail", 32'({exp_q[2].last, exp_q[2].data}), 32'h14363);
        chk("model_head_last", 32'(exp_q[0].last), 32'd0);
        run(8'd5, 8'd1, -1, 4, 12);

        // Backpressure on the second pair.
        build(8'd5, 8'd1);
        run(8'd5, 8'd1, 1, 4, 17);

        // Skipped zero-length line in the middle.
        ptr_tab[0] = {10'd2, 10'h100};
        ptr_tab[1] = {10'd0, 10'h200};
        ptr_tab[2] = {10'd1, 10'h300};
        build(8'd0, 8'd3);
        chk("model_skip_size", 32'(exp_q.size()), 32'd3);
        chk("model_skip_line", 32'(exp_q[2].line), 32'd2);
        run(8'd0, 8'd3, -1, 4, 18);

        // Empty request.
        build(8'd0, 8'd0);
        run(8'd0, 8'd0, -1, -1, 0);

        // Address wrap inside a line.
        ptr_tab[7] = {10'd3, 10'h3FE};
        cmem[10'h3FE] = 16'h5AFE; cmem[10'h3FF] = 16'h5AFF; cmem[10'h000] = 16'h5A00;
        build(8'd7, 8'd1);
        chk("model_wrap_data", 32'(exp_q[2].data), 32'h5A00);
        run(8'd7, 8'd1, -1, 4, 12);

        // Line-index wrap 0xFF -> 0x00.
        ptr_tab[8'hFF] = {10'd1, 10'h050};
        build(8'hFF, 8'd2);
        chk("model_linewrap", 32'({exp_q[0].line, exp_q[1].line}), 32'hFF00);
        run(8'hFF, 8'd2, -1, 4, 15);

        // Reset while a pair is pending in SEND.
        build(8'd5, 8'd1);
        d0 = done_seen;
        @(posedge clk); #1;
        go = 1'b1; first_line = 8'd5; num_lines = 8'd1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        go = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("midrst_reached_send", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'h3FF);
        chk("midrst_out_data", 32'(bus.out_data), 32'd0);
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_seen - d0), 32'd0);
        chk("midrst_still_idle", 32'(busy), 32'd0);
        build(8'd5, 8'd1);
        run(8'd5, 8'd1, -1, 4, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
